multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit.
//
// Moore FSM that sequences FETCH/DECODE/execute/writeback for R, lw, sw, beq, j, jal, addi
// and subi. It bounds every memory wait with a timeout that falls into an absorbing TRAP
// state. IRWrite and PCWrite in FETCH are the only outputs that depend on an input
// (mem_ready). All other outputs decode the current state only.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   opcode            instruction opcode, sampled and latched in DECODE
//   mem_ready         memory done strobe for the pending read/write
//   PCWrite .. ALUOp  datapath strobes and mux selects
//   state             current state encoding (debug)
//   trap              sticky fault flag, registered on entry to TRAP
module multicycle_control #(
  parameter int unsigned          OPCODE_W    = 6,
  parameter int unsigned          ALUOP_W     = 3,
  parameter logic [OPCODE_W-1:0]  SUBI_OP     = OPCODE_W'(6'h09),
  parameter int unsigned          MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemToReg,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [3:0]          state,
  output logic                trap
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'h03);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StIExec  = 4'd8,
    StIWb    = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12,
    StTrap   = 4'd13
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                trap_q;
  logic                mem_wait;
  logic                timeout;

  // States that wait on mem_ready and are therefore guarded by the timeout.
  assign mem_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout  = mem_wait && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT));

  // Next state, latched opcode and wait counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StTrap;
      end
      StDecode: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW:     state_d = StMemAdr;
          OP_R:             state_d = StRExec;
          OP_ADDI, SUBI_OP: state_d = StIExec;
          OP_BEQ:           state_d = StBranch;
          OP_J:             state_d = StJump;
          OP_JAL:           state_d = StJal;
          default:          state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StTrap;
      end
      StMemWr: begin
        if (mem_ready)    state_d = StFetch;
        else if (timeout) state_d = StTrap;
      end
      StMemWb:  state_d = StFetch;
      StRExec:  state_d = StRWb;
      StRWb:    state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StJal:    state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase

    // Any state change clears the counter, which covers entry to every wait state.
    if (state_d != state_q)         cnt_d = '0;
    else if (mem_wait && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // Moore outputs; IRWrite/PCWrite in FETCH are gated by mem_ready and held low in reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    RegDst      = 2'd0;
    MemToReg    = 2'd0;
    ALUSrcB     = 2'd0;
    PCSource    = 2'd0;
    ALUOp       = ALUOP_W'(0);

    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = mem_ready && !reset;
        PCWrite = mem_ready && !reset;
      end
      StDecode: ALUSrcB = 2'd3;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 2'd1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(4);
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
      end
      StIExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUOp   = (op_q == SUBI_OP) ? ALUOP_W'(3) : ALUOP_W'(2);
      end
      StIWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(1);
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      StJal: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemToReg = 2'd2;
      end
      StTrap:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      op_q    <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      trap_q  <= trap_q | (state_d == StTrap);
    end
  end

  assign state = state_q;
  assign trap  = trap_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irw;
    logic       regw;
    logic       alusrca;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       trap;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         n;
    int         st[7];
    logic [6:0] regw;   // bit j set when RegWrite is expected in step j
  } vec_t;

  logic clk, reset, mem_ready;
  logic [5:0] opcode;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] RegDst, MemToReg, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       trap;

  logic       t_PCWrite, t_PCWriteCond, t_IorD, t_MemRead, t_MemWrite, t_IRWrite;
  logic       t_RegWrite, t_ALUSrcA;
  logic [1:0] t_RegDst, t_MemToReg, t_ALUSrcB, t_PCSource;
  logic [2:0] t_ALUOp;
  logic [3:0] t_state;
  logic       t_trap;

  outs_t outs, t_outs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: current state plus a queue of planned states for the instruction.
  int m_st, m_wait, m_op;
  int m_q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .trap(trap)
  );

  multicycle_control #(.MEM_TIMEOUT(3)) dut_t (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(t_PCWrite), .PCWriteCond(t_PCWriteCond), .IorD(t_IorD), .MemRead(t_MemRead),
    .MemWrite(t_MemWrite), .IRWrite(t_IRWrite), .RegWrite(t_RegWrite), .ALUSrcA(t_ALUSrcA),
    .RegDst(t_RegDst), .MemToReg(t_MemToReg), .ALUSrcB(t_ALUSrcB), .PCSource(t_PCSource),
    .ALUOp(t_ALUOp), .state(t_state), .trap(t_trap)
  );

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                 RegDst, MemToReg, ALUSrcB, PCSource, ALUOp, trap};
  assign t_outs = {t_PCWrite, t_PCWriteCond, t_IorD, t_MemRead, t_MemWrite, t_IRWrite,
                   t_RegWrite, t_ALUSrcA, t_RegDst, t_MemToReg, t_ALUSrcB, t_PCSource,
                   t_ALUOp, t_trap};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Expected outputs straight from the per-state output table.
  function automatic outs_t exp_out(input int st, input logic rdy, input int op,
                                    input logic rst);
    outs_t e;
    e = '0;
    case (st)
      0: begin
        e.memrd = 1; e.alusrcb = 1;
        e.irw = rdy & ~rst; e.pcw = rdy & ~rst;
      end
      1: e.alusrcb = 3;
      2: begin e.alusrca = 1; e.alusrcb = 2; end
      3: begin e.memrd = 1; e.iord = 1; end
      4: begin e.regw = 1; e.memtoreg = 1; end
      5: begin e.memwr = 1; e.iord = 1; end
      6: begin e.alusrca = 1; e.aluop = 4; end
      7: begin e.regw = 1; e.regdst = 1; end
      8: begin e.alusrca = 1; e.alusrcb = 2; e.aluop = (op == 'h09) ? 3'd3 : 3'd2; end
      9: e.regw = 1;
      10: begin e.alusrca = 1; e.aluop = 1; e.pcwc = 1; e.pcsrc = 1; end
      11: begin e.pcw = 1; e.pcsrc = 2; end
      12: begin e.pcw = 1; e.pcsrc = 2; e.regw = 1; e.regdst = 2; e.memtoreg = 2; end
      default: e.trap = 1;
    endcase
    return e;
  endfunction

  // States visited after DECODE for each instruction class.
  task automatic plan(input int op);
    m_q.delete();
    case (op)
      'h23: m_q = '{2, 3, 4};
      'h2B: m_q = '{2, 5};
      'h00: m_q = '{6, 7};
      'h08, 'h09: m_q = '{8, 9};
      'h04: m_q = '{10};
      'h02: m_q = '{11};
      'h03: m_q = '{12};
      default: m_q = '{13};
    endcase
  endtask

  task automatic model_reset();
    m_st = 0; m_wait = 0; m_op = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic rdy, input int op, input int to);
    int prev;
    prev = m_st;
    if (m_st == 13) begin
      m_st = 13;
    end else if ((m_st == 0 || m_st == 3 || m_st == 5) && !rdy) begin
      if (m_wait == to) m_st = 13;
      else m_wait++;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      m_op = op;
      plan(op);
      m_st = m_q.pop_front();
    end else if (m_q.size() > 0) begin
      m_st = m_q.pop_front();
    end else begin
      m_st = 0;
    end
    if (m_st != prev) m_wait = 0;
  endtask

  vec_t tv[9];
  int legal_ops[8] = '{'h00, 'h23, 'h2B, 'h04, 'h02, 'h03, 'h08, 'h09};

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h00;

    tv[0].op = 6'h23; tv[0].n = 6; tv[0].st = '{0, 1, 2, 3, 4, 0, 0};     tv[0].regw = 7'b0010000;
    tv[1].op = 6'h2B; tv[1].n = 5; tv[1].st = '{0, 1, 2, 5, 0, 0, 0};     tv[1].regw = 7'b0;
    tv[2].op = 6'h00; tv[2].n = 5; tv[2].st = '{0, 1, 6, 7, 0, 0, 0};     tv[2].regw = 7'b0001000;
    tv[3].op = 6'h08; tv[3].n = 5; tv[3].st = '{0, 1, 8, 9, 0, 0, 0};     tv[3].regw = 7'b0001000;
    tv[4].op = 6'h09; tv[4].n = 5; tv[4].st = '{0, 1, 8, 9, 0, 0, 0};     tv[4].regw = 7'b0001000;
    tv[5].op = 6'h04; tv[5].n = 4; tv[5].st = '{0, 1, 10, 0, 0, 0, 0};    tv[5].regw = 7'b0;
    tv[6].op = 6'h02; tv[6].n = 4; tv[6].st = '{0, 1, 11, 0, 0, 0, 0};    tv[6].regw = 7'b0;
    tv[7].op = 6'h03; tv[7].n = 4; tv[7].st = '{0, 1, 12, 0, 0, 0, 0};    tv[7].regw = 7'b0000100;
    tv[8].op = 6'h3F; tv[8].n = 5; tv[8].st = '{0, 1, 13, 13, 13, 0, 0}; tv[8].regw = 7'b0;

    // Reset state: FETCH values with IRWrite/PCWrite held low although mem_ready=1.
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", {12'b0, outs}, {12'b0, exp_out(0, 1'b1, 0, 1'b1)});
    do_reset();

    // Table-driven instruction paths with mem_ready always high.
    for (int i = 0; i < 9; i++) begin
      opcode = tv[i].op;
      mem_ready = 1'b1;
      do_reset();
      for (int j = 0; j < tv[i].n; j++) begin
        #1;
        chk($sformatf("vec%0d_state%0d", i, j), 32'(state), 32'(tv[i].st[j]));
        chk($sformatf("vec%0d_regw%0d", i, j), 32'(RegWrite), 32'(tv[i].regw[j]));
        tick();
      end
    end

    // lw with opcode changed after DECODE: latched opcode still steers to MEMRD.
    opcode = 6'h23; mem_ready = 1'b1;
    do_reset();
    tick(); tick();
    opcode = 6'h2B;
    #1 chk("latch_memadr", 32'(state), 32'd2);
    tick();
    #1 chk("latch_memrd", 32'(state), 32'd3);
    tick();
    #1;
    chk("lw_wb_state", 32'(state), 32'd4);
    chk("lw_wb_outs", {12'b0, outs}, {12'b0, exp_out(4, 1'b1, 0, 1'b0)});
    tick();

    // jal
    opcode = 6'h03;
    do_reset();
    tick(); tick();
    #1;
    chk("jal_state", 32'(state), 32'd12);
    chk("jal_outs", {12'b0, outs}, {12'b0, exp_out(12, 1'b1, 0, 1'b0)});
    tick();
    #1 chk("jal_next", 32'(state), 32'd0);

    // subi then addi ALUOp in IEXEC; opcode flips during IEXEC to prove latching.
    opcode = 6'h09;
    do_reset();
    tick(); tick();
    opcode = 6'h08;
    #1 chk("subi_aluop", 32'(ALUOp), 32'd3);
    do_reset();
    tick(); tick();
    opcode = 6'h09;
    #1 chk("addi_aluop", 32'(ALUOp), 32'd2);

    // sw with 5 stall cycles: MemWrite high for 6 cycles, then FETCH, no trap.
    begin
      int mw_cycles;
      opcode = 6'h2B; mem_ready = 1'b1;
      do_reset();
      tick(); tick(); tick();
      mw_cycles = 0;
      mem_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        #1 if (MemWrite === 1'b1 && state === 4'd5) mw_cycles++;
        tick();
      end
      mem_ready = 1'b1;
      #1 if (MemWrite === 1'b1 && state === 4'd5) mw_cycles++;
      chk("stall_memwrite_cycles", 32'(mw_cycles), 32'd6);
      tick();
      #1;
      chk("stall_next", 32'(state), 32'd0);
      chk("stall_trap", 32'(trap), 32'd0);
    end

    // Timeout on the MEM_TIMEOUT=3 instance: 4 cycles in FETCH then TRAP.
    mem_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    #1 chk("to_before", 32'(t_state), 32'd0);
    tick();
    #1;
    chk("to_state", 32'(t_state), 32'd13);
    chk("to_trap", 32'(t_trap), 32'd1);
    chk("to_default_no_trap", 32'(state), 32'd0);
    for (int k = 0; k < 6; k++) begin
      mem_ready = 1'($urandom_range(1));
      opcode = 6'($urandom_range(63));
      tick();
      #1 chk("trap_hold", {12'b0, t_outs}, {12'b0, exp_out(13, mem_ready, 0, 1'b0)});
    end

    // Illegal opcode traps.
    opcode = 6'h3F; mem_ready = 1'b1;
    do_reset();
    tick(); tick();
    #1;
    chk("illegal_state", 32'(state), 32'd13);
    chk("illegal_trap", 32'(trap), 32'd1);

    // Asynchronous reset mid-MEMRD.
    opcode = 6'h23; mem_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1 chk("mid_memrd", 32'(state), 32'd3);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_trap", 32'(trap), 32'd0);
    chk("async_irw", 32'(IRWrite), 32'd0);
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    tick();
    #1 chk("after_reset_wr", 32'({RegWrite, MemWrite}), 32'd0);

    // Randomized run against the reference model.
    opcode = 6'h00; mem_ready = 1'b1;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      mem_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) opcode = 6'($urandom_range(63));
      else opcode = 6'(legal_ops[$urandom_range(7)]);
      #1;
      chk("rnd_state", 32'(state), 32'(m_st));
      chk("rnd_outs", {12'b0, outs}, {12'b0, exp_out(m_st, mem_ready, m_op, 1'b0)});
      model_step(mem_ready, int'(opcode), 15);
      tick();
      if (m_st == 13 && $urandom_range(3) == 0) begin
        do_reset();
        model_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
